// File: rtl/div_pkg.sv
// Shared types and helpers for the sequential restoring divider.
package div_pkg;

   typedef enum logic [1:0] {IDLE, CALC, DONE} div_state_t;

   function automatic int unsigned cnt_width(input int unsigned width);
      return $clog2(width + 1);
   endfunction

endpackage

// File: rtl/shift_left_register.sv
// Loadable left-shift register: per-bit mux2 feeding a dff, new bit enters at the LSB.
module shift_left_register #(
   parameter int unsigned WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             load_en,
   input  logic             shift_en,
   input  logic             shift_in,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   logic [WIDTH-1:0] shifted;
   logic [WIDTH-1:0] q_d;

   assign shifted = {q[WIDTH-2:0], shift_in};

   for (genvar i = 0; i < WIDTH; i++) begin : g_bit
      assign q_d[i] = load_en ? d[i] : (shift_en ? shifted[i] : q[i]);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         q <= '0;
      end else begin
         q <= q_d;
      end
   end

endmodule

// File: rtl/restoring_divider.sv
// Unsigned restoring divider: one shift/trial-subtract step per clock, start/busy/done handshake.
module restoring_divider
   import div_pkg::*;
#(
   parameter int unsigned WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] remainder,
   output logic             div_by_zero
);

   localparam int unsigned CW = cnt_width(WIDTH);

   div_state_t       state_q, state_d;
   logic [WIDTH-1:0] a_q;
   logic [WIDTH-1:0] m_q;
   logic [CW-1:0]    cnt_q;
   logic [WIDTH-1:0] q_val;
   logic [WIDTH-1:0] q_next;
   logic [WIDTH-1:0] a_next;
   logic [WIDTH:0]   a_shift;
   logic [WIDTH:0]   t;
   logic             accept;
   logic             load_q;
   logic             last;

   assign busy = (state_q == CALC);
   assign done = (state_q == DONE);
   assign last = (cnt_q == CW'(1));

   // The restored A is always below M, so WIDTH bits suffice; only the shifted form needs WIDTH+1.
   assign a_shift = {a_q, q_val[WIDTH-1]};
   assign t       = a_shift - {1'b0, m_q};
   assign a_next  = t[WIDTH] ? a_shift[WIDTH-1:0] : t[WIDTH-1:0];
   assign q_next  = {q_val[WIDTH-2:0], ~t[WIDTH]};

   shift_left_register #(
      .WIDTH(WIDTH)
   ) u_q_reg (
      .clk     (clk),
      .rst_n   (rst_n),
      .load_en (load_q),
      .shift_en(busy),
      .shift_in(~t[WIDTH]),
      .d       (dividend),
      .q       (q_val)
   );

   always_comb begin
      state_d = state_q;
      accept  = 1'b0;
      load_q  = 1'b0;
      case (state_q)
         IDLE, DONE: begin
            state_d = IDLE;
            if (start) begin
               accept = 1'b1;
               if (divisor != '0) begin
                  load_q  = 1'b1;
                  state_d = CALC;
               end else begin
                  state_d = DONE;
               end
            end
         end
         CALC: begin
            if (last) begin
               state_d = DONE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         a_q         <= '0;
         m_q         <= '0;
         cnt_q       <= '0;
         quotient    <= '0;
         remainder   <= '0;
         div_by_zero <= 1'b0;
      end else begin
         state_q <= state_d;
         if (load_q) begin
            m_q         <= divisor;
            a_q         <= '0;
            cnt_q       <= CW'(WIDTH);
            div_by_zero <= 1'b0;
         end else if (accept) begin
            quotient    <= '1;
            remainder   <= dividend;
            div_by_zero <= 1'b1;
         end else if (busy) begin
            a_q   <= a_next;
            cnt_q <= cnt_q - CW'(1);
            if (last) begin
               quotient  <= q_next;
               remainder <= a_next;
            end
         end
      end
   end

endmodule

// File: tb/tb_restoring_divider.sv
// Self-checking bench: directed cases plus randomized/exhaustive sweeps against an arithmetic model.
module tb_restoring_divider;

   logic clk = 1'b0;
   logic rst_n;

   logic       s8, b8, d8, z8;
   logic [7:0] dd8, dv8, q8, r8;
   logic       s4, b4, d4, z4;
   logic [3:0] dd4, dv4, q4, r4;
   logic        s16, b16, d16, z16;
   logic [15:0] dd16, dv16, q16, r16;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   restoring_divider #(.WIDTH(8)) u8 (
      .clk(clk), .rst_n(rst_n), .start(s8), .dividend(dd8), .divisor(dv8),
      .busy(b8), .done(d8), .quotient(q8), .remainder(r8), .div_by_zero(z8)
   );
   restoring_divider #(.WIDTH(4)) u4 (
      .clk(clk), .rst_n(rst_n), .start(s4), .dividend(dd4), .divisor(dv4),
      .busy(b4), .done(d4), .quotient(q4), .remainder(r4), .div_by_zero(z4)
   );
   restoring_divider #(.WIDTH(16)) u16 (
      .clk(clk), .rst_n(rst_n), .start(s16), .dividend(dd16), .divisor(dv16),
      .busy(b16), .done(d16), .quotient(q16), .remainder(r16), .div_by_zero(z16)
   );

   // Reference model: plain integer division, all-ones/dividend on divide-by-zero.
   function automatic void model(input int a, input int b, input int w,
                                 output int q, output int r, output bit z);
      if (b == 0) begin
         q = (1 << w) - 1;
         r = a;
         z = 1'b1;
      end else begin
         q = a / b;
         r = a % b;
         z = 1'b0;
      end
   endfunction

   // Issue one job on the 8-bit DUT; lat counts edges after the accepting edge until done.
   task automatic run8(input logic [7:0] a, input logic [7:0] b, output int lat,
                       output int busy_cnt, output bit to);
      @(negedge clk);
      dd8 = a; dv8 = b; s8 = 1'b1;
      @(negedge clk);
      s8 = 1'b0;
      lat = 0;
      busy_cnt = 0;
      while (!d8 && lat < 40) begin
         if (b8) busy_cnt++;
         @(negedge clk);
         lat++;
      end
      to = !d8;
   endtask

   task automatic test_reset;
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      checks++;
      if ({b8, d8, q8, r8, z8} !== 19'd0) begin
         failures++;
         $display("FAIL reset got busy=%0b done=%0b q=%0d r=%0d z=%0b want all 0",
                  b8, d8, q8, r8, z8);
      end
      rst_n = 1'b1;
   endtask

   task automatic test_directed;
      logic [7:0] as [5] = '{8'd100, 8'd255, 8'd5, 8'd255, 8'd37};
      logic [7:0] bs [5] = '{8'd7,   8'd1,   8'd9, 8'd255, 8'd0};
      int lat, bc, eq, er;
      bit to, ez;
      for (int i = 0; i < 5; i++) begin
         run8(as[i], bs[i], lat, bc, to);
         model(int'(as[i]), int'(bs[i]), 8, eq, er, ez);
         checks++;
         if (to || q8 !== eq[7:0] || r8 !== er[7:0] || z8 !== ez) begin
            failures++;
            $display("FAIL directed %0d/%0d got q=%0d r=%0d z=%0b to=%0b want q=%0d r=%0d z=%0b",
                     as[i], bs[i], q8, r8, z8, to, eq, er, ez);
         end
         checks++;
         if (lat != (ez ? 0 : 8) || bc != (ez ? 0 : 8)) begin
            failures++;
            $display("FAIL timing %0d/%0d got lat=%0d busy=%0d want lat=%0d busy=%0d",
                     as[i], bs[i], lat, bc, ez ? 0 : 8, ez ? 0 : 8);
         end
         @(negedge clk);
         checks++;
         if (d8 !== 1'b0 || b8 !== 1'b0 || q8 !== eq[7:0] || r8 !== er[7:0]) begin
            failures++;
            $display("FAIL hold %0d/%0d got done=%0b busy=%0b q=%0d r=%0d want 0 0 q=%0d r=%0d",
                     as[i], bs[i], d8, b8, q8, r8, eq, er);
         end
      end
   endtask

   task automatic test_back_to_back;
      int lat;
      @(negedge clk);
      dd8 = 8'd200; dv8 = 8'd3; s8 = 1'b1;
      @(negedge clk);
      lat = 0;
      while (!d8 && lat < 40) begin
         @(negedge clk);
         lat++;
      end
      checks++;
      if (!d8 || lat != 8 || q8 !== 8'd66 || r8 !== 8'd2) begin
         failures++;
         $display("FAIL b2b_first got done=%0b lat=%0d q=%0d r=%0d want 1 8 66 2", d8, lat, q8, r8);
      end
      dd8 = 8'd9; dv8 = 8'd4;
      @(negedge clk);
      s8 = 1'b0;
      checks++;
      if (b8 !== 1'b1 || d8 !== 1'b0) begin
         failures++;
         $display("FAIL b2b_restart got busy=%0b done=%0b want busy=1 done=0", b8, d8);
      end
      lat = 0;
      while (!d8 && lat < 40) begin
         @(negedge clk);
         lat++;
      end
      checks++;
      if (!d8 || lat != 8 || q8 !== 8'd2 || r8 !== 8'd1 || z8 !== 1'b0) begin
         failures++;
         $display("FAIL b2b_second got done=%0b lat=%0d q=%0d r=%0d want 1 8 2 1", d8, lat, q8, r8);
      end
   endtask

   task automatic test_mid_calc;
      int lat;
      @(negedge clk);
      dd8 = 8'd100; dv8 = 8'd7; s8 = 1'b1;
      @(negedge clk);
      s8 = 1'b0;
      lat = 0;
      repeat (3) begin
         @(negedge clk);
         lat++;
      end
      s8 = 1'b1; dd8 = 8'd9; dv8 = 8'd2;
      @(negedge clk);
      lat++;
      s8 = 1'b0; dd8 = 8'd255; dv8 = 8'd0;
      while (!d8 && lat < 40) begin
         @(negedge clk);
         lat++;
      end
      checks++;
      if (!d8 || lat != 8 || q8 !== 8'd14 || r8 !== 8'd2 || z8 !== 1'b0) begin
         failures++;
         $display("FAIL mid_calc got done=%0b lat=%0d q=%0d r=%0d z=%0b want 1 8 14 2 0",
                  d8, lat, q8, r8, z8);
      end
   endtask

   task automatic test_reset_mid_calc;
      int lat, bc, done_seen;
      bit to;
      @(negedge clk);
      dd8 = 8'd100; dv8 = 8'd7; s8 = 1'b1;
      @(negedge clk);
      s8 = 1'b0;
      repeat (3) @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      checks++;
      if ({b8, d8, q8, r8, z8} !== 19'd0) begin
         failures++;
         $display("FAIL reset_mid got busy=%0b done=%0b q=%0d r=%0d z=%0b want all 0",
                  b8, d8, q8, r8, z8);
      end
      done_seen = 0;
      repeat (12) begin
         @(negedge clk);
         if (d8 || b8) done_seen++;
      end
      checks++;
      if (done_seen != 0) begin
         failures++;
         $display("FAIL reset_abort got active_cycles=%0d want 0", done_seen);
      end
      run8(8'd50, 8'd6, lat, bc, to);
      checks++;
      if (to || lat != 8 || q8 !== 8'd8 || r8 !== 8'd2 || z8 !== 1'b0) begin
         failures++;
         $display("FAIL after_reset got lat=%0d q=%0d r=%0d z=%0b want 8 8 2 0", lat, q8, r8, z8);
      end
   endtask

   task automatic test_sweep_w4;
      int lat, eq, er;
      bit ez;
      for (int a = 0; a < 16; a++) begin
         for (int b = 0; b < 16; b++) begin
            @(negedge clk);
            dd4 = 4'(a); dv4 = 4'(b); s4 = 1'b1;
            @(negedge clk);
            s4 = 1'b0;
            lat = 0;
            while (!d4 && lat < 40) begin
               @(negedge clk);
               lat++;
            end
            model(a, b, 4, eq, er, ez);
            checks++;
            if (!d4 || q4 !== eq[3:0] || r4 !== er[3:0] || z4 !== ez || lat != (ez ? 0 : 4)) begin
               failures++;
               $display("FAIL w4 %0d/%0d got q=%0d r=%0d z=%0b lat=%0d want q=%0d r=%0d z=%0b",
                        a, b, q4, r4, z4, lat, eq, er, ez);
            end
            if (b != 0) begin
               checks++;
               if (int'(q4) * b + int'(r4) != a || int'(r4) >= b) begin
                  failures++;
                  $display("FAIL w4_invariant %0d/%0d got q=%0d r=%0d", a, b, q4, r4);
               end
            end
         end
      end
   endtask

   task automatic test_sweep_w16;
      int lat, a, b, eq, er;
      bit ez;
      for (int i = 0; i < 200; i++) begin
         a = int'($urandom_range(65535, 0));
         case (i % 4)
            0:       b = 0;
            1:       b = int'($urandom_range(15, 1));
            default: b = int'($urandom_range(65535, 1));
         endcase
         @(negedge clk);
         dd16 = 16'(a); dv16 = 16'(b); s16 = 1'b1;
         @(negedge clk);
         s16 = 1'b0;
         lat = 0;
         while (!d16 && lat < 60) begin
            @(negedge clk);
            lat++;
         end
         model(a, b, 16, eq, er, ez);
         checks++;
         if (!d16 || q16 !== eq[15:0] || r16 !== er[15:0] || z16 !== ez || lat != (ez ? 0 : 16))
         begin
            failures++;
            $display("FAIL w16 %0d/%0d got q=%0d r=%0d z=%0b lat=%0d want q=%0d r=%0d z=%0b",
                     a, b, q16, r16, z16, lat, eq, er, ez);
         end
         if (b != 0) begin
            checks++;
            if (int'(q16) * b + int'(r16) != a || int'(r16) >= b) begin
               failures++;
               $display("FAIL w16_invariant %0d/%0d got q=%0d r=%0d", a, b, q16, r16);
            end
         end
      end
   endtask

   initial begin
      rst_n = 1'b0;
      s8 = 1'b0;  dd8 = '0;  dv8 = '0;
      s4 = 1'b0;  dd4 = '0;  dv4 = '0;
      s16 = 1'b0; dd16 = '0; dv16 = '0;
      test_reset();
      test_directed();
      test_back_to_back();
      test_mid_calc();
      test_reset_mid_calc();
      test_sweep_w4();
      test_sweep_w16();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog got timeout want completion");
      $fatal(1, "watchdog expired");
   end

endmodule
